// File: rtl/packet_pkg.sv
// Shared constants and types for the framed GTX word stream (packet_send / packet_deframer).
package packet_pkg;

  localparam logic [31:0] SofWord   = 32'h0000_00FB;  // K27.7 in byte 0
  localparam logic [31:0] EofWord   = 32'h0000_00FD;  // K29.7 in byte 0
  localparam logic [31:0] CommaWord = 32'h0000_00BC;  // K28.5 in byte 0
  localparam logic [3:0]  KCtrl     = 4'b0001;

  // Header word layout: {len[15:0], 8'h00, type[7:0]}
  localparam int unsigned LenMsb  = 31;
  localparam int unsigned LenLsb  = 16;
  localparam int unsigned TypeMsb = 7;
  localparam int unsigned TypeLsb = 0;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StCheck,
    StEof
  } rx_state_e;

  function automatic logic is_kword(input logic [31:0] data, input logic [3:0] ctrl,
                                    input logic [31:0] word);
    return (ctrl == KCtrl) && (data == word);
  endfunction

endpackage

// File: rtl/packet_deframer.sv
// Receive-side frame parser: SOF/header/payload/checksum/EOF to a valid-qualified payload
// stream with per-packet status pulses and saturating good/bad packet counters.
module packet_deframer
  import packet_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic [31:0] gt_rx_data,
  input  logic [3:0]  gt_rx_ctrl,
  output logic        rx_packet_valid,
  output logic        rx_packet_sop,
  output logic        rx_packet_eop,
  output logic [31:0] rx_packet_data,
  output logic [7:0]  rx_packet_type,
  output logic [15:0] rx_packet_len,
  output logic        rx_packet_done,
  output logic        rx_packet_err,
  output logic [31:0] packet_cnt_o,
  output logic [31:0] error_packet_cnt_o
);

  localparam logic [15:0] MaxLenW = 16'(MAX_LEN);

  rx_state_e   state_q, state_d;
  logic [31:0] sum_q, sum_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mismatch_q, mismatch_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] len_q, len_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [31:0] bad_cnt_q, bad_cnt_d;

  logic        is_sof, is_eof, is_ctrl, close_err;
  logic [15:0] hdr_len;

  assign is_sof  = is_kword(gt_rx_data, gt_rx_ctrl, SofWord);
  assign is_eof  = is_kword(gt_rx_data, gt_rx_ctrl, EofWord);
  assign is_ctrl = (gt_rx_ctrl != 4'b0000);
  assign hdr_len = gt_rx_data[LenMsb:LenLsb];

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    type_d     = type_q;
    len_d      = len_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    close_err  = 1'b0;

    case (state_q)
      StIdle: begin
        if (is_sof) state_d = StHeader;
      end
      StHeader: begin
        if (is_ctrl || (hdr_len == 16'd0) || (hdr_len > MaxLenW)) begin
          close_err = 1'b1;
        end else begin
          type_d     = gt_rx_data[TypeMsb:TypeLsb];
          len_d      = hdr_len;
          sum_d      = gt_rx_data;
          cnt_d      = hdr_len;
          mismatch_d = 1'b0;
          state_d    = StPayload;
        end
      end
      StPayload: begin
        if (is_ctrl) begin
          close_err = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = gt_rx_data;
          sop_d   = (cnt_q == len_q);
          eop_d   = (cnt_q == 16'd1);
          sum_d   = sum_q + gt_rx_data;
          cnt_d   = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = StCheck;
        end
      end
      StCheck: begin
        // A bad checksum still waits for the EOF slot before the packet is closed.
        if (is_ctrl || (gt_rx_data != sum_q)) mismatch_d = 1'b1;
        state_d = StEof;
      end
      StEof: begin
        if (is_eof && !mismatch_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
          if (good_cnt_q != '1) good_cnt_d = good_cnt_q + 32'd1;
        end else begin
          close_err = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (close_err) begin
      err_d = 1'b1;
      if (bad_cnt_q != '1) bad_cnt_d = bad_cnt_q + 32'd1;
      // An SOF that kills the current packet starts the next one.
      state_d = is_sof ? StHeader : StIdle;
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      type_q     <= '0;
      len_q      <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      type_q     <= type_d;
      len_q      <= len_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign rx_packet_valid    = valid_q;
  assign rx_packet_sop      = sop_q;
  assign rx_packet_eop      = eop_q;
  assign rx_packet_data     = data_q;
  assign rx_packet_type     = type_q;
  assign rx_packet_len      = len_q;
  assign rx_packet_done     = done_q;
  assign rx_packet_err      = err_q;
  assign packet_cnt_o       = good_cnt_q;
  assign error_packet_cnt_o = bad_cnt_q;

endmodule

// File: tb/tb_packet_deframer.sv
// Randomized self-checking bench for packet_deframer; expectations come from the frames the
// bench itself builds (scoreboard of payload beats and close events).
module tb_packet_deframer;

  localparam int unsigned MaxLen = 1024;
  localparam int KGood    = 0;
  localparam int KBadCsum = 1;
  localparam int KBadEof  = 2;

  logic        rx_clk = 1'b0;
  logic        rst_n;
  logic [31:0] gt_rx_data;
  logic [3:0]  gt_rx_ctrl;
  logic        rx_packet_valid, rx_packet_sop, rx_packet_eop;
  logic [31:0] rx_packet_data;
  logic [7:0]  rx_packet_type;
  logic [15:0] rx_packet_len;
  logic        rx_packet_done, rx_packet_err;
  logic [31:0] packet_cnt_o, error_packet_cnt_o;

  always #5 rx_clk = ~rx_clk;

  packet_deframer #(.MAX_LEN(MaxLen)) dut (
    .rx_clk             (rx_clk),
    .rst_n              (rst_n),
    .gt_rx_data         (gt_rx_data),
    .gt_rx_ctrl         (gt_rx_ctrl),
    .rx_packet_valid    (rx_packet_valid),
    .rx_packet_sop      (rx_packet_sop),
    .rx_packet_eop      (rx_packet_eop),
    .rx_packet_data     (rx_packet_data),
    .rx_packet_type     (rx_packet_type),
    .rx_packet_len      (rx_packet_len),
    .rx_packet_done     (rx_packet_done),
    .rx_packet_err      (rx_packet_err),
    .packet_cnt_o       (packet_cnt_o),
    .error_packet_cnt_o (error_packet_cnt_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    bit          good;
    logic [7:0]  ptype;
    logic [15:0] len;
  } evt_t;

  beat_t       exp_q[$];
  evt_t        ev_q[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_good = 0;
  int          exp_bad = 0;
  logic [31:0] cnt_val = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every output beat and close pulse must match the next expectation.
  beat_t mon_b;
  evt_t  mon_e;
  always @(negedge rx_clk) begin
    if (rst_n) begin
      if (rx_packet_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 32'(rx_packet_data), 32'hxxxx_xxxx);
        end else begin
          mon_b = exp_q.pop_front();
          check_eq("payload_data", rx_packet_data, mon_b.data);
          check_eq("sop_eop", {30'd0, rx_packet_sop, rx_packet_eop}, {30'd0, mon_b.sop, mon_b.eop});
        end
      end
      if (rx_packet_done || rx_packet_err) begin
        check_eq("done_err_exclusive", {31'd0, rx_packet_done & rx_packet_err}, 32'd0);
        if (ev_q.size() == 0) begin
          check_eq("unexpected_close", {31'd0, rx_packet_done}, 32'hxxxx_xxxx);
        end else begin
          mon_e = ev_q.pop_front();
          check_eq("close_is_good", {31'd0, rx_packet_done}, {31'd0, mon_e.good});
          if (mon_e.good) begin
            check_eq("pkt_type", {24'd0, rx_packet_type}, {24'd0, mon_e.ptype});
            check_eq("pkt_len", {16'd0, rx_packet_len}, {16'd0, mon_e.len});
          end
        end
      end
    end
  end

  task automatic send_word(input logic [3:0] ctrl, input logic [31:0] data);
    @(posedge rx_clk);
    #1;
    gt_rx_ctrl = ctrl;
    gt_rx_data = data;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_word(4'b0001, 32'h0000_00BC);
  endtask

  task automatic push_evt(input bit good, input logic [7:0] ptype, input logic [15:0] len);
    evt_t e;
    e.good  = good;
    e.ptype = ptype;
    e.len   = len;
    ev_q.push_back(e);
    if (good) exp_good++;
    else exp_bad++;
  endtask

  // Sends SOF, header and the first n payload words of a len-word frame.
  task automatic send_head(input logic [7:0] ptype, input int len, input int n, input bit counting,
                           output logic [31:0] sum);
    beat_t       b;
    logic [31:0] hdr;
    logic [31:0] w;
    hdr = {len[15:0], 8'h00, ptype};
    send_word(4'b0001, 32'h0000_00FB);
    send_word(4'b0000, hdr);
    sum = hdr;
    for (int i = 0; i < n; i++) begin
      if (counting) begin
        w = cnt_val;
        cnt_val = cnt_val + 32'd1;
      end else begin
        w = $urandom;
      end
      b.data = w;
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      exp_q.push_back(b);
      send_word(4'b0000, w);
      sum = sum + w;
    end
  endtask

  task automatic send_frame(input logic [7:0] ptype, input int len, input int kind,
                            input bit counting);
    logic [31:0] sum;
    send_head(ptype, len, len, counting, sum);
    send_word(4'b0000, (kind == KBadCsum) ? sum + 32'd1 : sum);
    send_word(4'b0001, (kind == KBadEof) ? 32'h0000_00BC : 32'h0000_00FD);
    push_evt(kind == KGood, ptype, len[15:0]);
  endtask

  task automatic send_bad_hdr(input int len);
    send_word(4'b0001, 32'h0000_00FB);
    send_word(4'b0000, {len[15:0], 8'h00, 8'h11});
    push_evt(1'b0, 8'h00, 16'h0000);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_good_cnt"}, packet_cnt_o, 32'(exp_good));
    check_eq({tag, "_bad_cnt"}, error_packet_cnt_o, 32'(exp_bad));
    check_eq({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_events_left"}, 32'(ev_q.size()), 32'd0);
  endtask

  task automatic check_reset_state();
    check_eq("rst_valid", {31'd0, rx_packet_valid}, 32'd0);
    check_eq("rst_sop_eop", {30'd0, rx_packet_sop, rx_packet_eop}, 32'd0);
    check_eq("rst_data", rx_packet_data, 32'd0);
    check_eq("rst_type_len", {8'd0, rx_packet_type, rx_packet_len}, 32'd0);
    check_eq("rst_done_err", {30'd0, rx_packet_done, rx_packet_err}, 32'd0);
    check_eq("rst_good_cnt", packet_cnt_o, 32'd0);
    check_eq("rst_bad_cnt", error_packet_cnt_o, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] sum;
    rst_n      = 1'b0;
    gt_rx_ctrl = 4'b0001;
    gt_rx_data = 32'h0000_00BC;
    #23;
    check_reset_state();
    @(negedge rx_clk);
    rst_n = 1'b1;
    send_idle(3);

    // Single good frame, type 8, payload 1..4.
    cnt_val = 32'd1;
    send_frame(8'd8, 4, KGood, 1'b1);
    send_idle(3);
    check_counts("good4");

    // Same frame with a corrupted checksum.
    cnt_val = 32'd1;
    send_frame(8'd8, 4, KBadCsum, 1'b1);
    send_idle(3);
    check_counts("badcsum");

    // Header length out of range at both ends.
    send_bad_hdr(0);
    send_idle(1);
    send_bad_hdr(int'(MaxLen) + 1);
    send_idle(3);
    check_counts("badlen");

    // Largest legal length goes through.
    send_frame(8'hA5, int'(MaxLen), KGood, 1'b0);
    send_idle(2);
    check_counts("maxlen");

    // SOF in place of payload word 3 of a len-8 frame resyncs onto a len-2 frame.
    send_head(8'd3, 8, 2, 1'b0, sum);
    push_evt(1'b0, 8'h00, 16'h0000);
    send_frame(8'd5, 2, KGood, 1'b0);
    send_idle(2);
    check_counts("resync");

    // Back-to-back len-256 frames with a running count payload.
    cnt_val = 32'd0;
    for (int f = 0; f < 100; f++) send_frame(8'(f), 256, KGood, 1'b1);
    send_idle(3);
    check_counts("b2b");

    // Random mix of good, bad-checksum and bad-EOF frames with variable idle gaps.
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom), int'($urandom_range(1, 16)), int'($urandom_range(0, 2)), 1'b0);
      send_idle(int'($urandom_range(0, 2)));
    end
    send_idle(3);
    check_counts("random");

    // Reset mid-payload, release mid-frame; the tail must be discarded.
    send_head(8'd9, 8, 3, 1'b0, sum);
    @(posedge rx_clk);
    @(negedge rx_clk);
    #1;
    check_eq("pre_reset_beats_left", 32'(exp_q.size()), 32'd0);
    rst_n    = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    for (int i = 0; i < 2; i++) send_word(4'b0000, $urandom);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send_word(4'b0000, $urandom);
    send_word(4'b0000, $urandom);
    send_word(4'b0001, 32'h0000_00FD);
    send_idle(2);
    check_counts("after_reset_tail");
    send_frame(8'd7, 6, KGood, 1'b0);
    send_idle(3);
    check_counts("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_deframer.md
# packet_deframer

Receive-side decoder for the framed word stream emitted by `packet_send` over the GTX link. Sits after `word_align` in the `rx_clk` domain, parses SOF/header/payload/checksum/EOF from aligned 32-bit data plus K-character flags, and presents payload words as a valid-qualified stream with per-packet type, length and error status. Also keeps saturating good/bad packet counters for ILA/status readout.

## Interface
- `MAX_LEN`, 1024: largest accepted payload length in 32-bit words; larger header lengths are errors.
- `rx_clk`  in  1  receive word clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `gt_rx_data`  in  32  aligned receive word; byte 0 = [7:0].
- `gt_rx_ctrl`  in  4  per-byte K flags for `gt_rx_data`.
- `rx_packet_valid`  out  1  `rx_packet_data` holds a payload word.
- `rx_packet_sop`  out  1  with valid: first payload word.
- `rx_packet_eop`  out  1  with valid: last payload word.
- `rx_packet_data`  out  32  payload word.
- `rx_packet_type`  out  8  type of current packet; held until next header.
- `rx_packet_len`  out  16  header length of current packet; held until next header.
- `rx_packet_done`  out  1  one-cycle pulse: packet closed without error.
- `rx_packet_err`  out  1  one-cycle pulse: packet closed with error.
- `packet_cnt_o`  out  32  good packets, saturating.
- `error_packet_cnt_o`  out  32  bad packets, saturating.

## Operation
- Frame: SOF word `32'h0000_00FB`, ctrl `4'b0001` (K27.7); header word {len[15:0], 8'h00, type[7:0]}, ctrl 0; `len` payload words, ctrl 0; checksum word = mod-2^32 sum of header and all payload words, ctrl 0; EOF word `32'h0000_00FD`, ctrl `4'b0001` (K29.7). Any other word with ctrl≠0 is idle/comma.
- States: IDLE, HEADER, PAYLOAD, CHECK, EOF.
- IDLE: SOF → HEADER; everything else ignored.
- HEADER: ctrl≠0 → error close; len=0 or len>MAX_LEN → error close; else latch type/len, seed sum with header word, load word counter with len → PAYLOAD.
- PAYLOAD: each word ctrl=0 is emitted and added to sum; counter decrements; last word (counter=1) → CHECK. ctrl≠0 in PAYLOAD → error close (already-emitted words stand; no eop emitted).
- CHECK: ctrl≠0 or word≠sum → record mismatch, go EOF (packet still closes at EOF slot).
- EOF: EOF word → close, good if no mismatch else error; any other word → error close.
- Error close: pulse `rx_packet_err`, increment error counter, → IDLE. If the offending word is itself SOF, go directly to HEADER (resync, no dropped frame).
- Good close: pulse `rx_packet_done`, increment good counter.
- Counters saturate at `32'hFFFF_FFFF`.
- No backpressure: stream output must be consumed every cycle.

## Timing
- All outputs registered. Reset values: valid/sop/eop/done/err 0, data 0, type 0, len 0, both counters 0, state IDLE.
- Payload latency: word sampled in cycle N appears on `rx_packet_data` with valid in N+1.
- sop coincides with the first payload word; eop with the last; len=1 gives sop and eop on the same word.
- done/err assert in the cycle after the EOF slot word (or offending word) is sampled; counters update in that same cycle.
- done and err never assert together; at most one per packet.
- Back-to-back frames (SOF immediately after EOF) fully supported; zero idle cycles required.
- `rst_n` deassertion mid-frame: block starts in IDLE and discards until the next SOF.

## Structure
- Shared package `packet_pkg`: K-word constants (SOF, EOF, comma), ctrl pattern `4'b0001`, state enum, header field positions; the same package is used by `packet_send`.
- Single module; no sub-module needed. Checksum adder and word counter stay inline.

## Test plan
- One frame, type 8, len 4, payload 1..4, correct checksum → four valid words, sop on 1, eop on 4, `rx_packet_done` pulse, `packet_cnt_o`=1.
- Same frame with checksum +1 → payload emitted, `rx_packet_err` pulse, `error_packet_cnt_o`=1, `packet_cnt_o` unchanged.
- Header len=0, then len=MAX_LEN+1 → both error close, no valid, error count 2.
- SOF injected at payload word 3 of a len-8 frame, followed by a good len-2 frame → one err pulse, then good frame received, counts 1/1.
- 100 back-to-back len-256 frames with `cnt` payload → 100 done pulses, `packet_cnt_o`=100, no err.
- Assert `rst_n` low mid-payload then release mid-frame → all outputs 0, remainder ignored, next full frame received good.
